// File: rtl/apb_bridge_nport_pkg.sv
// Shared types and helpers for the N-port registered APB bridge.
package apb_bridge_nport_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int TO_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational port decoder: index, hit and one-hot select from the
// upper address bits.
module apb_addr_decode
    import apb_bridge_nport_pkg::*;
#(
    parameter int AW    = 32,
    parameter int N_SLV = 4,
    parameter int IDXW  = idx_width(N_SLV)
) (
    input  logic [AW-1:0]    i_paddr,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_hit,
    output logic [N_SLV-1:0] o_sel
);

    localparam logic [IDXW:0] NS = (IDXW+1)'(N_SLV);

    logic w_unused;

    assign w_unused = ^i_paddr[AW-IDXW-1:0];
    assign o_idx    = i_paddr[AW-1 -: IDXW];
    assign o_hit    = ({1'b0, o_idx} < NS);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            o_sel[i] = o_hit && (o_idx == IDXW'(i));
        end
    end

endmodule

// File: rtl/apb_bridge_nport.sv
// Registered APB bridge, one completer to N_SLV requesters, with decode-miss
// and ACCESS timeout errors. Optional byte strobes: APB_BRIDGE_PSTRB_EN.
module apb_bridge_nport
    import apb_bridge_nport_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int N_SLV   = 4,
    parameter int IDXW    = idx_width(N_SLV),
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_psel,
    input  logic                s_penable,
    input  logic                s_pwrite,
    input  logic [AW-1:0]       s_paddr,
    input  logic [DW-1:0]       s_pwdata,
    output logic [DW-1:0]       s_prdata,
    output logic                s_pready,
    output logic                s_pslverr,
`ifdef APB_BRIDGE_PSTRB_EN
    input  logic [DW/8-1:0]     s_pstrb,
    output logic [DW/8-1:0]     m_pstrb,
`endif
    output logic [N_SLV-1:0]    m_psel,
    output logic                m_penable,
    output logic                m_pwrite,
    output logic [AW-1:0]       m_paddr,
    output logic [DW-1:0]       m_pwdata,
    input  logic [N_SLV*DW-1:0] m_prdata,
    input  logic [N_SLV-1:0]    m_pready,
    input  logic [N_SLV-1:0]    m_pslverr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_write;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [IDXW-1:0]   r_idx;
    logic [N_SLV-1:0]  r_sel;
    logic [DW-1:0]     r_rdata;
    logic              r_err;
    logic [TO_W-1:0]   r_cnt;
`ifdef APB_BRIDGE_PSTRB_EN
    logic [DW/8-1:0]   r_strb;
`endif

    logic [IDXW-1:0]   w_idx;
    logic              w_hit;
    logic [N_SLV-1:0]  w_sel;
    logic              w_start;
    logic              w_active;
    logic              w_rdy;
    logic              w_slverr;
    logic [DW-1:0]     w_prdata;
    logic [TO_W:0]     w_cnt_inc;
    logic              w_timeout;

    apb_addr_decode #(
        .AW    (AW),
        .N_SLV (N_SLV),
        .IDXW  (IDXW)
    ) u_dec (
        .i_paddr (s_paddr),
        .o_idx   (w_idx),
        .o_hit   (w_hit),
        .o_sel   (w_sel)
    );

    assign w_start   = s_psel && !s_penable;
    assign w_rdy     = |(m_pready & r_sel);
    assign w_slverr  = |(m_pslverr & r_sel);
    assign w_prdata  = m_prdata[int'(r_idx)*DW +: DW];
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    // Compare against the post-increment count so ACCESS lasts TIMEOUT cycles.
    assign w_timeout = (TIMEOUT != 0) &&
                       (w_cnt_inc >= (TO_W+1)'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_nxt = w_hit ? SETUP : RESP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_rdy || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_active  = (r_state == SETUP) || (r_state == ACCESS);
        m_psel    = w_active ? r_sel : '0;
        m_penable = (r_state == ACCESS);
        m_pwrite  = w_active && r_write;
        m_paddr   = w_active ? r_addr : '0;
        m_pwdata  = w_active ? r_wdata : '0;
        s_pready  = (r_state == RESP);
        s_prdata  = s_pready ? r_rdata : '0;
        s_pslverr = s_pready && r_err;
`ifdef APB_BRIDGE_PSTRB_EN
        m_pstrb   = (w_active && r_write) ? r_strb : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
`ifdef APB_BRIDGE_PSTRB_EN
            r_strb  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_write <= s_pwrite;
                        r_addr  <= s_paddr;
                        r_wdata <= s_pwdata;
                        r_idx   <= w_idx;
                        r_sel   <= w_sel;
                        r_rdata <= '0;
                        r_err   <= !w_hit;
                        r_cnt   <= '0;
`ifdef APB_BRIDGE_PSTRB_EN
                        r_strb  <= s_pstrb;
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt != {TO_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                    if (w_rdy) begin
                        r_rdata <= r_write ? '0 : w_prdata;
                        r_err   <= w_slverr;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_nport.sv
// Scoreboard bench for apb_bridge_nport (N_SLV=3, TIMEOUT=8).
module tb_apb_bridge_nport;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_psel = 1'b0;
    logic          s_penable = 1'b0;
    logic          s_pwrite = 1'b0;
    logic [AW-1:0] s_paddr = '0;
    logic [DW-1:0] s_pwdata = '0;
    logic [DW-1:0] s_prdata;
    logic          s_pready;
    logic          s_pslverr;
`ifdef APB_BRIDGE_PSTRB_EN
    logic [3:0]    s_pstrb = '0;
    logic [3:0]    m_pstrb;
`endif
    logic [NS-1:0]    m_psel;
    logic             m_penable;
    logic             m_pwrite;
    logic [AW-1:0]    m_paddr;
    logic [DW-1:0]    m_pwdata;
    logic [NS*DW-1:0] m_prdata;
    logic [NS-1:0]    m_pready;
    logic [NS-1:0]    m_pslverr;

    apb_bridge_nport #(
        .AW(AW), .DW(DW), .N_SLV(NS), .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
`ifdef APB_BRIDGE_PSTRB_EN
        .s_pstrb   (s_pstrb),
        .m_pstrb   (m_pstrb),
`endif
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          start;
    } rsp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } dn_t;

    rsp_t rsp_q[$];
    dn_t  dn_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   acc_cnt = 0;

    logic [31:0] slv_rdata [NS];
    int          slv_wait  [NS];
    logic        slv_err   [NS];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        acc_cnt <= m_penable ? acc_cnt + 1 : 0;
    end

    // Downstream slaves; unselected ports assert ready/error as distractors.
    always_comb begin
        m_prdata  = '0;
        m_pready  = '0;
        m_pslverr = '0;
        for (int i = 0; i < NS; i++) begin
            m_prdata[i*DW +: DW] = slv_rdata[i];
            m_pready[i]  = m_psel[i] ?
                           (m_penable && acc_cnt >= slv_wait[i]) : 1'b1;
            m_pslverr[i] = m_psel[i] ? slv_err[i] : 1'b1;
        end
    end

    logic        exp_acc = 1'b0;
    logic [2:0]  last_sel;
    logic [31:0] last_addr;

    always @(negedge clk) begin
        if (rst) begin
            exp_acc = 1'b0;
        end else begin
            chk("onehot0", {31'b0, $onehot0(m_psel)}, 32'd1);
            if (s_pready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("s_prdata", s_prdata, r.rdata);
                    chk("s_pslverr", {31'b0, s_pslverr}, {31'b0, r.err});
                    chk("latency", cyc - r.start, r.lat);
                    chk("resp_psel", {29'b0, m_psel}, 32'd0);
                end
            end else begin
                chk("idle_rsp_zero", s_prdata | {31'b0, s_pslverr}, 32'd0);
            end
            if (exp_acc) begin
                chk("acc_penable", {31'b0, m_penable}, 32'd1);
                chk("acc_psel", {29'b0, m_psel}, {29'b0, last_sel});
                chk("acc_paddr", m_paddr, last_addr);
                exp_acc = 1'b0;
            end
            if (|m_psel && !m_penable) begin
                if (dn_q.size() == 0) begin
                    chk("unexpected_setup", {29'b0, m_psel}, 32'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("m_psel", {29'b0, m_psel}, {29'b0, d.sel});
                    chk("m_paddr", m_paddr, d.addr);
                    chk("m_pwrite", {31'b0, m_pwrite}, {31'b0, d.wr});
                    chk("m_pwdata", m_pwdata, d.wdata);
`ifdef APB_BRIDGE_PSTRB_EN
                    chk("m_pstrb", {28'b0, m_pstrb}, {28'b0, d.strb});
`endif
                    exp_acc   = 1'b1;
                    last_sel  = m_psel;
                    last_addr = m_paddr;
                end
            end
        end
    end

    task automatic push_dn(input logic [2:0] sel, input logic [31:0] addr,
                           input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb);
        dn_t d;
        d.sel = sel; d.addr = addr; d.wr = wr; d.wdata = wdata; d.strb = strb;
        dn_q.push_back(d);
    endtask

    task automatic setup_phase(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [3:0] strb);
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
        s_paddr = addr; s_pwdata = wdata;
`ifdef APB_BRIDGE_PSTRB_EN
        s_pstrb = strb;
`else
        if (strb === 4'bxxxx) $display("strb unknown");
`endif
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat);
        rsp_t r;
        int n;
        setup_phase(wr, addr, wdata, strb);
        r.rdata = exp_rd; r.err = exp_err; r.lat = exp_lat; r.start = cyc;
        rsp_q.push_back(r);
        @(negedge clk);
        s_penable = 1'b1;
        n = 0;
        while (!s_pready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("pready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            slv_rdata[i] = 32'hAAAA_5550 + i;
            slv_wait[i]  = 0;
            slv_err[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_pready", {31'b0, s_pready}, 32'd0);
        chk("rst_psel", {29'b0, m_psel}, 32'd0);
        chk("rst_penable", {31'b0, m_penable}, 32'd0);
        chk("rst_paddr", m_paddr, 32'd0);
        rst = 1'b0;

        push_dn(3'b100, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 3);

        slv_wait[1] = 3; slv_rdata[1] = 32'h1234_5678;
        push_dn(3'b010, 32'h4000_0024, 1'b0, 32'h0, 4'b0000);
        xfer(1'b0, 32'h4000_0024, 32'h0, 4'b1111, 32'h1234_5678, 1'b0, 6);

        xfer(1'b0, 32'hC000_0000, 32'h0, 4'b1111, 32'h0, 1'b1, 1);

        slv_wait[0] = 1; slv_err[0] = 1'b1; slv_rdata[0] = 32'hCAFE_F00D;
        push_dn(3'b001, 32'h0000_0100, 1'b0, 32'h0, 4'b0000);
        xfer(1'b0, 32'h0000_0100, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b1, 4);

        slv_wait[0] = 1000; slv_err[0] = 1'b0;
        push_dn(3'b001, 32'h0000_0040, 1'b0, 32'h0, 4'b0000);
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'b1111, 32'h0, 1'b1, 10);

        // Reset in the middle of ACCESS; no upstream response is expected.
        push_dn(3'b001, 32'h0000_0008, 1'b1, 32'h1111_2222, 4'b1111);
        setup_phase(1'b1, 32'h0000_0008, 32'h1111_2222, 4'b1111);
        @(negedge clk);
        s_penable = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_penable", {31'b0, m_penable}, 32'd1);
        rst = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk);
        chk("mid_rst_psel", {29'b0, m_psel}, 32'd0);
        chk("mid_rst_penable", {31'b0, m_penable}, 32'd0);
        chk("mid_rst_pwrite", {31'b0, m_pwrite}, 32'd0);
        chk("mid_rst_paddr", m_paddr, 32'd0);
        chk("mid_rst_pwdata", m_pwdata, 32'd0);
        chk("mid_rst_pready", {31'b0, s_pready}, 32'd0);
        rst = 1'b0;

        slv_wait[2] = 2;
        push_dn(3'b100, 32'h8000_0004, 1'b0, 32'h0, 4'b0000);
        xfer(1'b0, 32'h8000_0004, 32'h0, 4'b0101, 32'hAAAA_5552, 1'b0, 5);

        repeat (4) @(negedge clk);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("dn_q_empty", dn_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_bridge_nport.md
Name: apb_bridge_nport

Overview:
- Registered APB bridge: one upstream completer port fanned out to N_SLV downstream requester ports.
- Decodes the target port from the upper address bits and re-times each transfer through a 4-state FSM.
- Adds a per-transfer timeout with error response and decode-miss error response, neither of which the single-pair bridge has.
- Sits between the system APB segment and a cluster of peripheral APB slaves.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- N_SLV, 4, number of downstream ports (1..16).
- IDXW, $clog2(N_SLV) (min 1), width of the port-select field, taken from paddr[AW-1 -: IDXW].
- TIMEOUT, 255, max ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- s_psel in 1: upstream select.
- s_penable in 1: upstream enable.
- s_pwrite in 1: upstream write.
- s_paddr in AW: upstream address.
- s_pwdata in DW: upstream write data.
- s_prdata out DW: upstream read data.
- s_pready out 1: upstream ready.
- s_pslverr out 1: upstream error.
- m_psel out N_SLV: one-hot downstream select.
- m_penable out 1: shared downstream enable.
- m_pwrite out 1: shared downstream write.
- m_paddr out AW: shared downstream address.
- m_pwdata out DW: shared downstream write data.
- m_prdata in N_SLV*DW: downstream read data; port i occupies [i*DW +: DW].
- m_pready in N_SLV: per-port ready.
- m_pslverr in N_SLV: per-port error.

Behaviour:
- Single clock, clk. Reset rst is synchronous, active-high.
- While rst=1 the bridge ignores all inputs. At the next edge it forces FSM=IDLE and drives every output to 0, including mid-transfer; the downstream transfer is abandoned.
- IDLE:
  - On s_psel=1 & s_penable=0, capture s_pwrite/s_paddr/s_pwdata and decode idx=s_paddr[AW-1 -: IDXW].
  - If idx<N_SLV, go to SETUP. Otherwise (miss), go to RESP with err=1, rdata=0.
- SETUP, 1 cycle:
  - m_psel[idx]=1, m_penable=0.
  - m_paddr, m_pwrite and m_pwdata come from the captured registers and stay stable until the transfer leaves ACCESS.
  - Next state: ACCESS.
- ACCESS:
  - m_psel[idx]=1, m_penable=1, timeout counter increments each cycle.
  - On m_pready[idx]=1: latch m_prdata slice idx (reads only; 0 for writes) and m_pslverr[idx], then go to RESP.
  - On counter==TIMEOUT (TIMEOUT>0) with m_pready[idx]=0: latch err=1, rdata=0, then go to RESP.
  - m_pready, m_pslverr and m_prdata of non-selected ports are ignored.
- RESP, 1 cycle:
  - m_psel=0, m_penable=0.
  - s_pready=1, with s_prdata/s_pslverr from the latched registers.
  - Next state: IDLE.
- Upstream outputs:
  - s_pready=0 in every other state, which holds the upstream access phase in wait.
  - s_prdata and s_pslverr are 0 whenever s_pready=0.
- Minimum latency: upstream setup at cycle 0; downstream SETUP at 1; ACCESS at 2; s_pready at 3 if m_pready is immediate. A decode miss responds at cycle 1.
- Back-to-back: a new upstream setup is accepted only in IDLE, one cycle after RESP. No pipelining across transfers.
- If upstream drops s_psel mid-transfer, the downstream transfer still completes and RESP is still issued. The bridge does not abort.
- Timeout counter is 16 bits, cleared on entry to SETUP, and saturates. TIMEOUT=0 means wait forever.
- m_psel is always one-hot or zero. Never more than one bit set.

Optional Feature:
- Macro: APB_BRIDGE_PSTRB_EN.
- Defined:
  - Adds port s_pstrb (in, DW/8) and port m_pstrb (out, DW/8).
  - Bridge captures s_pstrb in IDLE. m_pstrb drives the captured value for writes and 0 for reads.
  - m_pstrb is 0 outside SETUP/ACCESS.
- Undefined: both ports are absent. Writes are full-width.

Decomposition:
- Package apb_bridge_nport_pkg contains:
  - state enum {IDLE, SETUP, ACCESS, RESP}.
  - localparam TO_W=16.
  - Function idx_width(n) returning max(1, $clog2(n)).
- Sub-module apb_addr_decode, purely combinational:
  - Inputs: paddr.
  - Outputs: idx, hit, and one-hot sel.
  - Parameters: AW, N_SLV, IDXW.

Test Plan:
- Write to port 2 with m_pready[2] tied 1 (paddr=0x8000_0010, pwdata=0xDEAD_BEEF, N_SLV=4) -> m_psel=4'b0100 at cycle 1, m_penable at cycle 2, m_pwdata=0xDEAD_BEEF, s_pready=1 with s_pslverr=0 at cycle 3.
- Read from port 1 with m_pready[1] low for 3 ACCESS cycles, m_prdata slice 1=0x1234_5678 -> s_pready=1 at cycle 6 with s_prdata=0x1234_5678; no s_pready before that.
- Decode miss (N_SLV=3, paddr=0xC000_0000) -> no m_psel activity; s_pready=1, s_pslverr=1, s_prdata=0 at cycle 1.
- Timeout (TIMEOUT=8), port 0 never ready -> ACCESS lasts 8 cycles; s_pready=1 and s_pslverr=1 follow; m_psel returns to 0.
- rst=1 asserted during ACCESS -> next edge: all outputs 0, FSM IDLE; the next upstream transfer completes normally.
- APB_BRIDGE_PSTRB_EN defined: write with s_pstrb=4'b0011 -> m_pstrb=4'b0011. A read with s_pstrb=4'b1111 -> m_pstrb=0.
